reg_write_sched: RTL and testbench

REG_WRITE_SCHED -- requirements
Module: reg_write_sched

---
 rtl/reg_write_sched_if.sv | 37 +++
 rtl/reg_write_sched.sv | 153 +++++++++++++++
 tb/tb_reg_write_sched.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_write_sched_if.sv
// reg_write_sched_if: bundle between write-back sources and the register-file
// write scheduler.
//   src_valid/src_addr/src_data : per-source write-back request (0 even pipe,
//                                 1 odd pipe, 2 load, 3 channel)
//   src_ready                   : per-source combinational grant
//   reg_write_*_1 / reg_write_*_2 : registered register-file write ports
//   starve_flag                 : per-source forced-state indication
// master = the sources / register file side, slave = the scheduler.
interface reg_write_sched_if;
   logic [3:0]            src_valid;
   logic [3:0][6:0]       src_addr;
   logic [3:0][127:0]     src_data;
   logic [3:0]            src_ready;
   logic                  reg_write_en_1;
   logic [6:0]            reg_write_addr_1;
   logic [127:0]          reg_write_data_1;
   logic                  reg_write_en_2;
   logic [6:0]            reg_write_addr_2;
   logic [127:0]          reg_write_data_2;
   logic [3:0]            starve_flag;

   modport master (
      output src_valid, src_addr, src_data,
      input  src_ready,
      input  reg_write_en_1, reg_write_addr_1, reg_write_data_1,
      input  reg_write_en_2, reg_write_addr_2, reg_write_data_2,
      input  starve_flag
   );

   modport slave (
      input  src_valid, src_addr, src_data,
      output src_ready,
      output reg_write_en_1, reg_write_addr_1, reg_write_data_1,
      output reg_write_en_2, reg_write_addr_2, reg_write_data_2,
      output starve_flag
   );
endinterface

// File: rtl/reg_write_sched.sv
// reg_write_sched: merges four write-back sources onto two register-file
// write ports. Rotating priority picks port 1, the next non-conflicting
// source picks port 2; a source left waiting STARVE_LIMIT cycles is forced
// onto port 1. Writes appear on the ports one cycle after the handshake.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   bus   : reg_write_sched_if.slave (requests in, grants/ports/flags out)

// Per-source wait counter and starvation flag.
module reg_write_sched_lane #(
   parameter int STARVE_LIMIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic valid,
   input  logic ready,
   output logic forced,
   output logic starve
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

   logic [CW-1:0] cnt, cnt_nxt;

   always_comb begin
      cnt_nxt = cnt;
      if (!valid || ready)  cnt_nxt = '0;
      else if (cnt != LIM)  cnt_nxt = cnt + CW'(1);
   end

   // starve mirrors cnt==LIM but is its own flop so the output is registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         starve <= 1'b0;
      end else begin
         cnt    <= cnt_nxt;
         starve <= (cnt_nxt == LIM);
      end
   end

   assign forced = (cnt == LIM);
endmodule

module reg_write_sched #(
   parameter int STARVE_LIMIT = 8
) (
   input  logic clk,
   input  logic rst,
   reg_write_sched_if.slave bus
);
   localparam int NSRC = 4;

   logic [1:0]      rr_ptr;
   logic [1:0]      g1, g2, idx, last, pos1, pos2;
   logic            g1_vld, g2_vld;
   logic [NSRC-1:0] gnt, ready, forced, starve;

   logic            en1_q, en2_q;
   logic [6:0]      addr1_q, addr2_q;
   logic [127:0]    data1_q, data2_q;

   always_comb begin
      g1_vld = 1'b0;
      g1     = '0;
      g2_vld = 1'b0;
      g2     = '0;
      idx    = '0;
      for (int k = 0; k < NSRC; k++) begin
         idx = rr_ptr + 2'(k);
         if (!g1_vld && bus.src_valid[idx]) begin
            g1_vld = 1'b1;
            g1     = idx;
         end
      end
      // Forced sources override the rotating pick; lowest index wins.
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (bus.src_valid[i] && forced[i]) begin
            g1_vld = 1'b1;
            g1     = 2'(i);
         end
      end
      // Port 2 never takes the port-1 address, so the ports cannot collide.
      for (int k = 0; k < NSRC; k++) begin
         idx = rr_ptr + 2'(k);
         if (g1_vld && !g2_vld && idx != g1 && bus.src_valid[idx] &&
             bus.src_addr[idx] != bus.src_addr[g1]) begin
            g2_vld = 1'b1;
            g2     = idx;
         end
      end
   end

   // Pointer moves past whichever grant sits later in the current scan order.
   always_comb begin
      pos1 = g1 - rr_ptr;
      pos2 = g2 - rr_ptr;
      last = g1;
      if (g2_vld && pos2 > pos1) last = g2;
   end

   always_comb begin
      gnt = '0;
      if (g1_vld) gnt[g1] = 1'b1;
      if (g2_vld) gnt[g2] = 1'b1;
   end

   assign ready         = gnt & {NSRC{rst}};
   assign bus.src_ready = ready;

   for (genvar i = 0; i < NSRC; i++) begin : g_lane
      reg_write_sched_lane #(.STARVE_LIMIT(STARVE_LIMIT)) u_lane (
         .clk    (clk),
         .rst    (rst),
         .valid  (bus.src_valid[i]),
         .ready  (ready[i]),
         .forced (forced[i]),
         .starve (starve[i])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr  <= '0;
         en1_q   <= 1'b0;
         en2_q   <= 1'b0;
         addr1_q <= '0;
         addr2_q <= '0;
         data1_q <= '0;
         data2_q <= '0;
      end else begin
         en1_q <= g1_vld;
         en2_q <= g2_vld;
         if (g1_vld) begin
            rr_ptr  <= last + 2'd1;
            addr1_q <= bus.src_addr[g1];
            data1_q <= bus.src_data[g1];
         end
         if (g2_vld) begin
            addr2_q <= bus.src_addr[g2];
            data2_q <= bus.src_data[g2];
         end
      end
   end

   assign bus.reg_write_en_1   = en1_q;
   assign bus.reg_write_addr_1 = addr1_q;
   assign bus.reg_write_data_1 = data1_q;
   assign bus.reg_write_en_2   = en2_q;
   assign bus.reg_write_addr_2 = addr2_q;
   assign bus.reg_write_data_2 = data2_q;
   assign bus.starve_flag      = starve;
endmodule

// File: tb/tb_reg_write_sched.sv
// Bench for reg_write_sched: directed scenarios plus randomized traffic,
// checked against a queue/array reference model through a scoreboard.
module tb_reg_write_sched;
   localparam int LIM = 2;

   logic clk = 1'b0;
   logic rst;
   reg_write_sched_if bus();

   reg_write_sched #(.STARVE_LIMIT(LIM)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct { int due; logic [3:0] rdy; } rdy_t;
   typedef struct {
      int due;
      logic en1; logic [6:0] a1; logic [127:0] d1;
      logic en2; logic [6:0] a2; logic [127:0] d2;
      logic [3:0] stv;
   } out_t;
   typedef struct { string name; logic [127:0] act; logic [127:0] exp; } dchk_t;

   rdy_t  rdy_q[$];
   out_t  out_q[$];
   dchk_t dchk_q[$];
   int checks = 0, failures = 0, cyc = 0;
   bit chk_en = 1'b0;

   // reference model state
   int           m_cnt[4];
   int           m_ptr;
   logic [6:0]   m_a1, m_a2;
   logic [127:0] m_d1, m_d2;
   logic [3:0]   m_gnt;

   // stimulus state
   logic [3:0]   drv_v;
   logic [6:0]   drv_a[4];
   logic [127:0] drv_d[4];

   always @(posedge clk) cyc <= cyc + 1;

   // all comparisons happen here
   always @(negedge clk) begin
      rdy_t r; out_t o; dchk_t c;
      while (dchk_q.size() > 0) begin
         c = dchk_q.pop_front();
         checks++;
         if (c.act !== c.exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h t=%0t", c.name, c.act, c.exp, $time);
         end
      end
      if (chk_en) begin
         while (rdy_q.size() > 0 && rdy_q[0].due <= cyc) begin
            r = rdy_q.pop_front();
            checks++;
            if (bus.src_ready !== r.rdy) begin
               failures++;
               $display("FAIL src_ready: got %b expected %b t=%0t", bus.src_ready, r.rdy, $time);
            end
         end
         while (out_q.size() > 0 && out_q[0].due <= cyc) begin
            o = out_q.pop_front();
            checks++;
            if (bus.reg_write_en_1 !== o.en1 || bus.reg_write_addr_1 !== o.a1 || bus.reg_write_data_1 !== o.d1) begin
               failures++;
               $display("FAIL port1: got en=%b a=%0d d=%0h expected en=%b a=%0d d=%0h t=%0t",
                        bus.reg_write_en_1, bus.reg_write_addr_1, bus.reg_write_data_1, o.en1, o.a1, o.d1, $time);
            end
            checks++;
            if (bus.reg_write_en_2 !== o.en2 || bus.reg_write_addr_2 !== o.a2 || bus.reg_write_data_2 !== o.d2) begin
               failures++;
               $display("FAIL port2: got en=%b a=%0d d=%0h expected en=%b a=%0d d=%0h t=%0t",
                        bus.reg_write_en_2, bus.reg_write_addr_2, bus.reg_write_data_2, o.en2, o.a2, o.d2, $time);
            end
            checks++;
            if (bus.starve_flag !== o.stv) begin
               failures++;
               $display("FAIL starve_flag: got %b expected %b t=%0t", bus.starve_flag, o.stv, $time);
            end
         end
      end
   end

   task automatic dcheck(input string name, input logic [127:0] act, input logic [127:0] exp);
      dchk_t c;
      c.name = name; c.act = act; c.exp = exp;
      dchk_q.push_back(c);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_ptr = 0; m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0; m_gnt = '0;
      drv_v = '0;
   endtask

   // One arbitration cycle: drive inputs, predict grants and the next outputs.
   task automatic apply();
      int g1, g2, last, id;
      out_t o; rdy_t r;
      @(posedge clk); #1;
      bus.src_valid = drv_v;
      for (int i = 0; i < 4; i++) begin
         bus.src_addr[i] = drv_a[i];
         bus.src_data[i] = drv_d[i];
      end
      g1 = -1;
      for (int i = 0; i < 4; i++)
         if (g1 < 0 && drv_v[i] && m_cnt[i] == LIM) g1 = i;
      for (int k = 0; k < 4; k++) begin
         id = (m_ptr + k) % 4;
         if (g1 < 0 && drv_v[id]) g1 = id;
      end
      g2 = -1;
      if (g1 >= 0)
         for (int k = 0; k < 4; k++) begin
            id = (m_ptr + k) % 4;
            if (g2 < 0 && id != g1 && drv_v[id] && drv_a[id] != drv_a[g1]) g2 = id;
         end
      m_gnt = '0;
      if (g1 >= 0) m_gnt[g1] = 1'b1;
      if (g2 >= 0) m_gnt[g2] = 1'b1;
      if (g1 >= 0) begin
         last = g1;
         if (g2 >= 0 && ((g2 - m_ptr + 4) % 4) > ((g1 - m_ptr + 4) % 4)) last = g2;
         m_ptr = (last + 1) % 4;
         m_a1 = drv_a[g1]; m_d1 = drv_d[g1];
      end
      if (g2 >= 0) begin
         m_a2 = drv_a[g2]; m_d2 = drv_d[g2];
      end
      for (int i = 0; i < 4; i++) begin
         if (!drv_v[i] || m_gnt[i]) m_cnt[i] = 0;
         else if (m_cnt[i] < LIM)   m_cnt[i] = m_cnt[i] + 1;
      end
      r.due = cyc; r.rdy = m_gnt;
      o.due = cyc + 1;
      o.en1 = (g1 >= 0); o.a1 = m_a1; o.d1 = m_d1;
      o.en2 = (g2 >= 0); o.a2 = m_a2; o.d2 = m_d2;
      for (int i = 0; i < 4; i++) o.stv[i] = (m_cnt[i] == LIM);
      rdy_q.push_back(r);
      out_q.push_back(o);
   endtask

   // New data only for sources that were granted or idle; pending ones hold.
   task automatic refresh(input logic [3:0] v);
      for (int i = 0; i < 4; i++)
         if (m_gnt[i] || !drv_v[i]) drv_d[i] = {$urandom, $urandom, $urandom, $urandom};
      drv_v = v;
   endtask

   task automatic rand_fill(input int ar);
      for (int i = 0; i < 4; i++) begin
         if (drv_v[i] && !m_gnt[i]) begin
            if ($urandom_range(0, 9) == 0) drv_v[i] = 1'b0;
         end else begin
            drv_v[i] = ($urandom_range(0, 3) != 0);
            drv_a[i] = 7'($urandom_range(0, ar));
            drv_d[i] = {$urandom, $urandom, $urandom, $urandom};
         end
      end
   endtask

   // Asynchronous reset landing mid-cycle, right after the last applied edge.
   task automatic do_reset(input bit pre_chk, input logic [6:0] pre_addr);
      @(posedge clk); #2;
      if (pre_chk) begin
         dcheck("pre_rst_en1", 128'(bus.reg_write_en_1), 128'(1));
         dcheck("pre_rst_addr1", 128'(bus.reg_write_addr_1), 128'(pre_addr));
      end
      chk_en = 1'b0;
      rst = 1'b0;
      bus.src_valid = 4'hF;
      #1;
      dcheck("rst_en1", 128'(bus.reg_write_en_1), 128'(0));
      dcheck("rst_en2", 128'(bus.reg_write_en_2), 128'(0));
      dcheck("rst_addr1", 128'(bus.reg_write_addr_1), 128'(0));
      dcheck("rst_addr2", 128'(bus.reg_write_addr_2), 128'(0));
      dcheck("rst_data1", bus.reg_write_data_1, 128'(0));
      dcheck("rst_data2", bus.reg_write_data_2, 128'(0));
      dcheck("rst_starve", 128'(bus.starve_flag), 128'(0));
      dcheck("rst_ready", 128'(bus.src_ready), 128'(0));
      rdy_q.delete();
      out_q.delete();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      dcheck("rst_ready_held", 128'(bus.src_ready), 128'(0));
      bus.src_valid = '0;
      @(negedge clk);
      rst = 1'b1;
      chk_en = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.src_valid = '0;
      for (int i = 0; i < 4; i++) begin
         bus.src_addr[i] = '0; bus.src_data[i] = '0;
         drv_a[i] = '0; drv_d[i] = '0;
      end
      model_reset();
      #1 rst = 1'b0;
      #3;
      dcheck("init_en1", 128'(bus.reg_write_en_1), 128'(0));
      dcheck("init_en2", 128'(bus.reg_write_en_2), 128'(0));
      dcheck("init_addr1", 128'(bus.reg_write_addr_1), 128'(0));
      dcheck("init_data2", bus.reg_write_data_2, 128'(0));
      dcheck("init_starve", 128'(bus.starve_flag), 128'(0));
      dcheck("init_ready", 128'(bus.src_ready), 128'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      chk_en = 1'b1;

      // single request on source 0
      drv_a[0] = 7'd5; drv_d[0] = {16{8'hA5}}; drv_v = 4'b0001;
      apply();
      drv_v = '0; apply(); apply();

      // full load from reset at distinct addresses
      do_reset(1'b0, 7'd0);
      for (int i = 0; i < 4; i++) drv_a[i] = 7'(i + 1);
      repeat (6) begin refresh(4'hF); apply(); end
      drv_v = '0; apply();

      // address conflict between sources 0 and 1
      do_reset(1'b0, 7'd0);
      drv_a[0] = 7'd9; drv_a[1] = 7'd9;
      repeat (3) begin refresh(4'b0011); apply(); end
      drv_v = '0; apply();

      // all sources on one address: forcing and starve flags
      do_reset(1'b0, 7'd0);
      for (int i = 0; i < 4; i++) drv_a[i] = 7'd7;
      repeat (8) begin refresh(4'hF); apply(); end
      refresh(4'b1001); apply(); apply(); apply();
      drv_v = '0; apply();

      // source 2 valid one cycle, never granted, then withdrawn
      do_reset(1'b0, 7'd0);
      drv_a[0] = 7'd1; drv_a[1] = 7'd2; drv_a[2] = 7'd3;
      refresh(4'b0111); apply();
      drv_v = '0; apply(); apply();

      // reset while a write to address 12 is on port 1
      drv_a[0] = 7'd12; refresh(4'b0001); apply();
      drv_v = '0;
      do_reset(1'b1, 7'd12);
      for (int i = 0; i < 4; i++) drv_a[i] = 7'(20 + i);
      refresh(4'hF); apply();
      drv_v = '0; apply();

      // randomized traffic with occasional asynchronous resets
      for (int n = 0; n < 2000; n++) begin
         rand_fill((n % 2 == 0) ? 3 : 15);
         apply();
         if ($urandom_range(0, 299) == 0) do_reset(1'b0, 7'd0);
      end
      drv_v = '0; apply(); apply();
      @(posedge clk);
      @(negedge clk); #1;
      dcheck("drain_out", 128'(out_q.size()), 128'(0));
      dcheck("drain_rdy", 128'(rdy_q.size()), 128'(0));
      @(negedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
